pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_seq_pkg.sv | 18 +
 rtl/pc_seq_iter_cnt.sv | 22 ++
 rtl/pc_sequencer.sv | 112 +++++++++++
 tb/tb_pc_sequencer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// Shared types and defaults for the program-counter sequencer.
// Optional build macro PC_SEQ_ITER_LIMIT_EN enables the loop-count limit.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } pc_state_t;

    localparam int PC_W_DEF    = 8;
    localparam int PC_LAST_DEF = 4;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/pc_seq_iter_cnt.sv
// Saturating 8-bit completed-loop counter; used only when PC_SEQ_ITER_LIMIT_EN is defined.
module pc_seq_iter_cnt
    import pc_seq_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       inc,
    output logic [7:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 8'd0;
        end else if (clr) begin
            cnt <= 8'd0;
        end else if (inc) begin
            cnt <= sat_inc8(cnt);
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer with halt/jump/stall control and wrap at PC_LAST.
// Defining PC_SEQ_ITER_LIMIT_EN adds max_iter and halts after that many wraps.
//
// state  | meaning
// IDLE   | after reset, waiting for start
// RUN    | PC sequencing, pc_valid high
// HALTED | stopped, PC held, done high; start restarts at 0
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int PC_W    = PC_W_DEF,
    parameter int PC_LAST = PC_LAST_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            stall,
    input  logic            jmp_valid,
    input  logic [PC_W-1:0] jmp_addr,
    input  logic            halt_req,
`ifdef PC_SEQ_ITER_LIMIT_EN
    input  logic [7:0]      max_iter,
`endif
    output logic [PC_W-1:0] pc_out,
    output logic            pc_valid,
    output logic            wrap,
    output logic            jmp_err,
    output logic            done,
    output logic [7:0]      iter_cnt
);

    localparam logic [PC_W-1:0] LAST = PC_W'(PC_LAST);

    pc_state_t state;
    logic      limit_hit;

`ifdef PC_SEQ_ITER_LIMIT_EN
    logic iter_inc;
    logic iter_clr;

    assign iter_inc  = (state == RUN) && !halt_req && !jmp_valid && !stall && (pc_out == LAST);
    assign iter_clr  = (state != RUN) && start;
    // Halt on the wrap whose count lands exactly on the limit; 0 means unlimited.
    assign limit_hit = (max_iter != 8'd0) && (sat_inc8(iter_cnt) == max_iter);

    pc_seq_iter_cnt u_iter_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (iter_clr),
        .inc   (iter_inc),
        .cnt   (iter_cnt)
    );
`else
    assign iter_cnt  = 8'd0;
    assign limit_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pc_out   <= '0;
            pc_valid <= 1'b0;
            wrap     <= 1'b0;
            jmp_err  <= 1'b0;
            done     <= 1'b0;
        end else begin
            wrap    <= 1'b0;
            jmp_err <= 1'b0;
            case (state)
                IDLE, HALTED: begin
                    if (start) begin
                        state    <= RUN;
                        pc_out   <= '0;
                        pc_valid <= 1'b1;
                        done     <= 1'b0;
                    end
                end
                RUN: begin
                    if (halt_req) begin
                        state    <= HALTED;
                        pc_valid <= 1'b0;
                        done     <= 1'b1;
                    end else if (jmp_valid) begin
                        if (jmp_addr <= LAST) begin
                            pc_out <= jmp_addr;
                        end else begin
                            jmp_err <= 1'b1;
                        end
                    end else if (!stall) begin
                        if (pc_out == LAST) begin
                            pc_out <= '0;
                            wrap   <= 1'b1;
                            if (limit_hit) begin
                                state    <= HALTED;
                                pc_valid <= 1'b0;
                                done     <= 1'b1;
                            end
                        end else begin
                            pc_out <= pc_out + 1'b1;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    pc_valid <= 1'b0;
                    done     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: per-cycle model compare plus directed literal checks.
module tb_pc_sequencer;

    localparam int PC_W    = 8;
    localparam int PC_LAST = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start = 1'b0;
    logic            stall = 1'b0;
    logic            jmp_valid = 1'b0;
    logic [PC_W-1:0] jmp_addr = '0;
    logic            halt_req = 1'b0;
`ifdef PC_SEQ_ITER_LIMIT_EN
    logic [7:0]      max_iter = 8'd0;
`endif
    logic [PC_W-1:0] pc_out;
    logic            pc_valid;
    logic            wrap;
    logic            jmp_err;
    logic            done;
    logic [7:0]      iter_cnt;

    int tests = 0;
    int fails = 0;

    pc_sequencer #(.PC_W(PC_W), .PC_LAST(PC_LAST)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stall     (stall),
        .jmp_valid (jmp_valid),
        .jmp_addr  (jmp_addr),
        .halt_req  (halt_req),
`ifdef PC_SEQ_ITER_LIMIT_EN
        .max_iter  (max_iter),
`endif
        .pc_out    (pc_out),
        .pc_valid  (pc_valid),
        .wrap      (wrap),
        .jmp_err   (jmp_err),
        .done      (done),
        .iter_cnt  (iter_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: mode 0=idle, 1=running, 2=stopped.
    int m_mode = 0;
    int m_pc   = 0;
    int m_wrap = 0;
    int m_err  = 0;
    int m_iter = 0;

    always @(posedge clk or negedge rst_n) begin : model
        int nxt_iter;
        if (!rst_n) begin
            m_mode <= 0; m_pc <= 0; m_wrap <= 0; m_err <= 0; m_iter <= 0;
        end else begin
            m_wrap <= 0;
            m_err  <= 0;
            if (m_mode != 1) begin
                if (start) begin
                    m_mode <= 1; m_pc <= 0; m_iter <= 0;
                end
            end else if (halt_req) begin
                m_mode <= 2;
            end else if (jmp_valid) begin
                if (int'(jmp_addr) <= PC_LAST) m_pc <= int'(jmp_addr);
                else m_err <= 1;
            end else if (!stall) begin
                m_pc <= (m_pc + 1) % (PC_LAST + 1);
                if (m_pc == PC_LAST) begin
                    m_wrap <= 1;
                    nxt_iter = (m_iter < 255) ? m_iter + 1 : 255;
`ifdef PC_SEQ_ITER_LIMIT_EN
                    m_iter <= nxt_iter;
                    if (max_iter != 0 && nxt_iter == int'(max_iter)) m_mode <= 2;
`endif
                end
            end
        end
    end

    always @(negedge clk) begin
        check("pc_out",   int'(pc_out),   m_pc);
        check("pc_valid", int'(pc_valid), (m_mode == 1) ? 1 : 0);
        check("wrap",     int'(wrap),     m_wrap);
        check("jmp_err",  int'(jmp_err),  m_err);
        check("done",     int'(done),     (m_mode == 2) ? 1 : 0);
        check("iter_cnt", int'(iter_cnt), m_iter);
    end

    task automatic wait_pc(input int target);
        int n = 0;
        while (int'(pc_out) != target && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("wait_pc", int'(pc_out), target);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int seq[7]  = '{0, 1, 2, 3, 4, 0, 1};
        int wseq[7] = '{0, 0, 0, 0, 0, 1, 0};

        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_pc", int'(pc_out), 0);
        check("rst_valid", int'(pc_valid), 0);
        check("rst_done", int'(done), 0);

        // Free-running sequence with wrap
        pulse_start();
        for (int i = 0; i < 7; i++) begin
            check("seq_pc", int'(pc_out), seq[i]);
            check("seq_wrap", int'(wrap), wseq[i]);
            check("seq_valid", int'(pc_valid), 1);
            @(negedge clk);
        end

        // Legal jump to PC_LAST, then wrap
        wait_pc(2);
        jmp_valid = 1'b1; jmp_addr = 8'd4;
        @(negedge clk);
        jmp_valid = 1'b0;
        check("jmp_pc", int'(pc_out), 4);
        check("jmp_nowrap", int'(wrap), 0);
        @(negedge clk);
        check("jmp_then_wrap_pc", int'(pc_out), 0);
        check("jmp_then_wrap", int'(wrap), 1);

        // Out-of-range jump is rejected
        wait_pc(2);
        jmp_valid = 1'b1; jmp_addr = 8'd9;
        @(negedge clk);
        jmp_valid = 1'b0;
        check("badjmp_pc", int'(pc_out), 2);
        check("badjmp_err", int'(jmp_err), 1);
        @(negedge clk);
        check("badjmp_next_pc", int'(pc_out), 3);
        check("badjmp_err_clr", int'(jmp_err), 0);

        // Jump to the current address holds
        jmp_valid = 1'b1; jmp_addr = 8'd3;
        @(negedge clk);
        jmp_valid = 1'b0;
        check("selfjmp_pc", int'(pc_out), 3);
        check("selfjmp_err", int'(jmp_err), 0);
        @(negedge clk);
        check("selfjmp_next", int'(pc_out), 4);

        // Halt wins over jump and stall
        wait_pc(3);
        halt_req = 1'b1; jmp_valid = 1'b1; jmp_addr = 8'd1; stall = 1'b1;
        @(negedge clk);
        halt_req = 1'b0; jmp_valid = 1'b0; stall = 1'b0;
        check("halt_pc", int'(pc_out), 3);
        check("halt_done", int'(done), 1);
        check("halt_valid", int'(pc_valid), 0);
        repeat (3) @(negedge clk);
        check("halt_hold_pc", int'(pc_out), 3);
        pulse_start();
        check("restart_pc", int'(pc_out), 0);
        check("restart_valid", int'(pc_valid), 1);
        check("restart_done", int'(done), 0);

        // Stall for three edges
        wait_pc(1);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_hold", int'(pc_out), 1);
        end
        stall = 1'b0;
        @(negedge clk);
        check("stall_release", int'(pc_out), 2);

        // Asynchronous reset between edges with a pending halt
        wait_pc(3);
        halt_req = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("arst_pc", int'(pc_out), 0);
        check("arst_valid", int'(pc_valid), 0);
        check("arst_done", int'(done), 0);
        check("arst_wrap", int'(wrap), 0);
        @(negedge clk);
        halt_req = 1'b0;
        rst_n = 1'b1;
        jmp_valid = 1'b1; jmp_addr = 8'd2; stall = 1'b1; halt_req = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_ignore_pc", int'(pc_out), 0);
        check("idle_ignore_valid", int'(pc_valid), 0);
        check("idle_ignore_done", int'(done), 0);
        jmp_valid = 1'b0; stall = 1'b0; halt_req = 1'b0;
        pulse_start();
        check("post_rst_start_pc", int'(pc_out), 0);
        @(negedge clk);
        check("post_rst_adv", int'(pc_out), 1);

`ifdef PC_SEQ_ITER_LIMIT_EN
        max_iter = 8'd2;
        halt_req = 1'b1;
        @(negedge clk);
        halt_req = 1'b0;
        pulse_start();
        begin
            int n = 0;
            while (!done && n < 40) begin
                @(negedge clk);
                n++;
            end
        end
        check("lim_done", int'(done), 1);
        check("lim_iter", int'(iter_cnt), 2);
        check("lim_pc", int'(pc_out), 0);
        repeat (3) @(negedge clk);
        check("lim_hold_pc", int'(pc_out), 0);
        check("lim_hold_done", int'(done), 1);
        max_iter = 8'd0;
        pulse_start();
        check("unlim_iter_clr", int'(iter_cnt), 0);
        repeat (30) @(negedge clk);
        check("unlim_valid", int'(pc_valid), 1);
        check("unlim_iter", int'(iter_cnt), 6);
`endif

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
